// File: rtl/pulse_param_ctrl_if.sv
// UART-side handshake bundle for pulse_param_ctrl.
//   received        one-cycle strobe, rx_byte valid in that cycle
//   rx_byte         received byte
//   recv_error      one-cycle framing-error strobe
//   is_transmitting UART transmitter busy
//   transmit        one-cycle request to send tx_byte
//   tx_byte         acknowledge byte
// master: the UART side; slave: the command front end.
interface pulse_param_ctrl_if;
  logic       received;
  logic [7:0] rx_byte;
  logic       recv_error;
  logic       is_transmitting;
  logic       transmit;
  logic [7:0] tx_byte;

  modport master (
    output received, rx_byte, recv_error, is_transmitting,
    input  transmit, tx_byte
  );

  modport slave (
    input  received, rx_byte, recv_error, is_transmitting,
    output transmit, tx_byte
  );
endinterface

// File: rtl/pulse_param_ctrl.sv
// Command front end and parameter scheduler for the pump-probe pulse generator.
// Assembles 5-byte frames (D[31:0] LSB first, then control byte C) into a
// shadow register set, commits the whole set atomically on the next
// cycle_start while pending, and returns a checksum acknowledge byte.
//
// Ports:
//   clk          12 MHz system clock
//   reset        asynchronous active-high reset
//   uart         UART handshake bundle (slave modport)
//   cycle_start  pulse-period boundary strobe, synchronous to clk
//   period, p1width, p2width, delay, p2start, sync_up   active timing values
//   pump, pp_on, att_probe, att3, att_pump              active control values
//   pending      shadow set awaits commit
//   cmd_error    one-cycle strobe on an aborted or unknown frame
//
// Build option: define PARAM_ACK_EN to include the acknowledge path;
// otherwise transmit and tx_byte are tied to 0.
module pulse_param_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 120000
) (
  input  logic                clk,
  input  logic                reset,
  pulse_param_ctrl_if.slave   uart,
  input  logic                cycle_start,
  output logic [31:0]         period,
  output logic [31:0]         p1width,
  output logic [31:0]         p2width,
  output logic [31:0]         delay,
  output logic [31:0]         p2start,
  output logic [31:0]         sync_up,
  output logic                pump,
  output logic                pp_on,
  output logic [7:0]          att_probe,
  output logic [7:0]          att3,
  output logic [7:0]          att_pump,
  output logic                pending,
  output logic                cmd_error
);

  localparam logic [31:0] PeriodRst  = 32'd2000000;
  localparam logic [31:0] P1widthRst = 32'd30;
  localparam logic [31:0] P2widthRst = 32'd30;
  localparam logic [31:0] DelayRst   = 32'd2000;
  localparam logic [31:0] TmoLast    = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic {StRx, StDecode} state_e;

  state_e      state_q, state_d;
  logic [2:0]  byte_idx_q, byte_idx_d;
  logic [31:0] data_q, data_d;
  logic [7:0]  ctrl_q, ctrl_d;
  logic [31:0] tmo_q, tmo_d;
  logic        abort;
  logic        bad_cmd;
  logic        dec_write;
  logic        commit;
  logic        pending_q, pending_d;
  logic        cmd_error_q;

  // Shadow set
  logic [31:0] sh_period_q, sh_p1width_q, sh_p2width_q, sh_delay_q;
  logic        sh_pump_q, sh_pp_on_q;
  logic [7:0]  sh_att_probe_q, sh_att3_q, sh_att_pump_q;

  // Active set
  logic [31:0] period_q, p1width_q, p2width_q, delay_q, p2start_q, sync_up_q;
  logic        pump_q, pp_on_q;
  logic [7:0]  att_probe_q, att3_q, att_pump_q;

  // Receive FSM and inter-byte timeout
  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    data_d     = data_q;
    ctrl_d     = ctrl_q;
    tmo_d      = tmo_q;
    abort      = 1'b0;
    bad_cmd    = 1'b0;
    unique case (state_q)
      StRx: begin
        if (uart.recv_error) begin
          // Abort has priority over a coincident byte, which is dropped.
          abort      = 1'b1;
          byte_idx_d = 3'd0;
          tmo_d      = '0;
        end else if (uart.received) begin
          tmo_d = '0;
          if (byte_idx_q == 3'd4) begin
            ctrl_d     = uart.rx_byte;
            byte_idx_d = 3'd0;
            state_d    = StDecode;
          end else begin
            data_d[{byte_idx_q[1:0], 3'b000} +: 8] = uart.rx_byte;
            byte_idx_d = byte_idx_q + 3'd1;
          end
        end else if (byte_idx_q != 3'd0) begin
          if (tmo_q == TmoLast) begin
            abort      = 1'b1;
            byte_idx_d = 3'd0;
            tmo_d      = '0;
          end else begin
            tmo_d = tmo_q + 32'd1;
          end
        end
      end
      StDecode: begin
        bad_cmd = (ctrl_q > 8'd6);
        state_d = StRx;
      end
    endcase
  end

  assign dec_write = (state_q == StDecode) && (ctrl_q <= 8'd5);
  assign commit    = cycle_start && pending_q;

  // A write in the same cycle as a commit stays pending for the next boundary.
  always_comb begin
    pending_d = pending_q;
    if (commit)    pending_d = 1'b0;
    if (dec_write) pending_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StRx;
      byte_idx_q  <= 3'd0;
      data_q      <= '0;
      ctrl_q      <= '0;
      tmo_q       <= '0;
      pending_q   <= 1'b0;
      cmd_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_idx_q  <= byte_idx_d;
      data_q      <= data_d;
      ctrl_q      <= ctrl_d;
      tmo_q       <= tmo_d;
      pending_q   <= pending_d;
      cmd_error_q <= abort | bad_cmd;
    end
  end

  // Shadow writes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_period_q    <= PeriodRst;
      sh_p1width_q   <= P1widthRst;
      sh_p2width_q   <= P2widthRst;
      sh_delay_q     <= DelayRst;
      sh_pump_q      <= 1'b1;
      sh_pp_on_q     <= 1'b0;
      sh_att_probe_q <= 8'hFF;
      sh_att3_q      <= 8'hFF;
      sh_att_pump_q  <= 8'h00;
    end else if (dec_write) begin
      case (ctrl_q)
        8'd0: sh_delay_q   <= data_q;
        8'd1: sh_period_q  <= data_q;
        8'd2: sh_p1width_q <= data_q;
        8'd3: sh_p2width_q <= data_q;
        8'd4: sh_pump_q    <= data_q[0];
        8'd5: begin
          sh_att_probe_q <= data_q[7:0];
          sh_att3_q      <= data_q[15:8];
          sh_att_pump_q  <= data_q[23:16];
          sh_pp_on_q     <= data_q[24];
        end
        default: ;
      endcase
    end
  end

  // Atomic commit; derived values come from the shadow set being committed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_q    <= PeriodRst;
      p1width_q   <= P1widthRst;
      p2width_q   <= P2widthRst;
      delay_q     <= DelayRst;
      p2start_q   <= P1widthRst + DelayRst;
      sync_up_q   <= P1widthRst + DelayRst + P2widthRst;
      pump_q      <= 1'b1;
      pp_on_q     <= 1'b0;
      att_probe_q <= 8'hFF;
      att3_q      <= 8'hFF;
      att_pump_q  <= 8'h00;
    end else if (commit) begin
      period_q    <= sh_period_q;
      p1width_q   <= sh_p1width_q;
      p2width_q   <= sh_p2width_q;
      delay_q     <= sh_delay_q;
      p2start_q   <= sh_p1width_q + sh_delay_q;
      sync_up_q   <= sh_p1width_q + sh_delay_q + sh_p2width_q;
      pump_q      <= sh_pump_q;
      pp_on_q     <= sh_pp_on_q;
      att_probe_q <= sh_att_probe_q;
      att3_q      <= sh_att3_q;
      att_pump_q  <= sh_att_pump_q;
    end
  end

`ifdef PARAM_ACK_EN
  logic [7:0] cs;
  logic       ack_valid_q;
  logic [7:0] tx_byte_q;

  assign cs = data_q[31:24] + data_q[23:16] + data_q[15:8] + data_q[7:0];

  // One-entry holding register; a fresh acknowledge replaces an unsent one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_valid_q <= 1'b0;
      tx_byte_q   <= 8'h00;
    end else if (state_q == StDecode) begin
      ack_valid_q <= 1'b1;
      tx_byte_q   <= bad_cmd ? ~cs : cs;
    end else if (uart.transmit) begin
      ack_valid_q <= 1'b0;
    end
  end

  assign uart.transmit = ack_valid_q & ~uart.is_transmitting;
  assign uart.tx_byte  = tx_byte_q;
`else
  logic unused_is_transmitting;
  assign unused_is_transmitting = uart.is_transmitting;
  assign uart.transmit = 1'b0;
  assign uart.tx_byte  = 8'h00;
`endif

  assign period    = period_q;
  assign p1width   = p1width_q;
  assign p2width   = p2width_q;
  assign delay     = delay_q;
  assign p2start   = p2start_q;
  assign sync_up   = sync_up_q;
  assign pump      = pump_q;
  assign pp_on     = pp_on_q;
  assign att_probe = att_probe_q;
  assign att3      = att3_q;
  assign att_pump  = att_pump_q;
  assign pending   = pending_q;
  assign cmd_error = cmd_error_q;

endmodule

// File: tb/tb_pulse_param_ctrl.sv
// Directed testbench for pulse_param_ctrl. Expected acknowledge values depend
// on whether PARAM_ACK_EN is defined for the build.
module tb_pulse_param_ctrl;

  localparam int unsigned Tmo = 40;
`ifdef PARAM_ACK_EN
  localparam bit AckEn = 1'b1;
`else
  localparam bit AckEn = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        cycle_start;
  logic [31:0] period, p1width, p2width, delay, p2start, sync_up;
  logic        pump, pp_on, pending, cmd_error;
  logic [7:0]  att_probe, att3, att_pump;

  pulse_param_ctrl_if u_if ();

  pulse_param_ctrl #(
    .TIMEOUT_CYCLES (Tmo)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .uart        (u_if),
    .cycle_start (cycle_start),
    .period      (period),
    .p1width     (p1width),
    .p2width     (p2width),
    .delay       (delay),
    .p2start     (p2start),
    .sync_up     (sync_up),
    .pump        (pump),
    .pp_on       (pp_on),
    .att_probe   (att_probe),
    .att3        (att3),
    .att_pump    (att_pump),
    .pending     (pending),
    .cmd_error   (cmd_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int tx_cnt   = 0;
  int err_cnt  = 0;

  always @(negedge clk) begin
    if (u_if.transmit === 1'b1) tx_cnt++;
    if (cmd_error === 1'b1)     err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    u_if.received = 1'b1;
    u_if.rx_byte  = b;
    tick();
    u_if.received = 1'b0;
  endtask

  task automatic send_raw(input logic [31:0] d, input logic [7:0] c);
    for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
    send_byte(c);
  endtask

  task automatic send_frame(input logic [31:0] d, input logic [7:0] c);
    send_raw(d, c);
    repeat (3) tick();
  endtask

  task automatic pulse_cycle_start();
    cycle_start = 1'b1;
    tick();
    cycle_start = 1'b0;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int e0, t0;

  initial begin
    reset              = 1'b1;
    cycle_start        = 1'b0;
    u_if.received      = 1'b0;
    u_if.rx_byte       = 8'h00;
    u_if.recv_error    = 1'b0;
    u_if.is_transmitting = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state
    check("rst_period", period, 32'd2000000);
    check("rst_p1width", p1width, 32'd30);
    check("rst_p2width", p2width, 32'd30);
    check("rst_delay", delay, 32'd2000);
    check("rst_p2start", p2start, 32'd2030);
    check("rst_sync_up", sync_up, 32'd2060);
    check("rst_pump", pump, 1'b1);
    check("rst_pp_on", pp_on, 1'b0);
    check("rst_att_probe", att_probe, 8'hFF);
    check("rst_att3", att3, 8'hFF);
    check("rst_att_pump", att_pump, 8'h00);
    check("rst_pending", pending, 1'b0);
    check("rst_transmit", u_if.transmit, 1'b0);
    check("rst_tx_byte", u_if.tx_byte, 8'h00);
    check("rst_cmd_error", cmd_error, 1'b0);

    // delay=2000 with exact acknowledge timing
    t0 = tx_cnt;
    send_raw(32'h0000_07D0, 8'd0);
    check("dec_cycle_transmit", u_if.transmit, 1'b0);
    check("dec_cycle_pending", pending, 1'b0);
    tick();
    check("wr_pending", pending, 1'b1);
    check("ack_transmit", u_if.transmit, AckEn);
    check("ack_tx_byte", u_if.tx_byte, AckEn ? 8'hD7 : 8'h00);
    tick();
    check("ack_one_cycle", u_if.transmit, 1'b0);
    check("ack_count", tx_cnt - t0, AckEn ? 1 : 0);
    pulse_cycle_start();
    check("c0_delay", delay, 32'd2000);
    check("c0_p2start", p2start, 32'd2030);
    check("c0_pending", pending, 1'b0);

    // p1width=100 waits for the boundary
    send_frame(32'd100, 8'd2);
    check("p1_no_commit", p1width, 32'd30);
    check("p1_pending", pending, 1'b1);
    check("p1_ack", u_if.tx_byte, AckEn ? 8'h64 : 8'h00);
    pulse_cycle_start();
    check("p1_width", p1width, 32'd100);
    check("p1_p2start", p2start, 32'd2100);
    check("p1_sync_up", sync_up, 32'd2130);
    check("p1_pending_clr", pending, 1'b0);

    // cycle_start with nothing pending has no effect
    pulse_cycle_start();
    check("idle_commit_p1", p1width, 32'd100);

    // Attenuators
    send_frame(32'h0100_40FF, 8'd5);
    check("att_ack", u_if.tx_byte, AckEn ? 8'h40 : 8'h00);
    pulse_cycle_start();
    check("att_probe", att_probe, 8'hFF);
    check("att3", att3, 8'h40);
    check("att_pump", att_pump, 8'h00);
    check("att_pp_on", pp_on, 1'b1);

    // Inter-byte timeout
    e0 = err_cnt;
    t0 = tx_cnt;
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    repeat (Tmo - 2) tick();
    check("tmo_not_early", err_cnt - e0, 0);
    repeat (6) tick();
    check("tmo_err", err_cnt - e0, 1);
    check("tmo_no_tx", tx_cnt - t0, 0);
    check("tmo_pending", pending, 1'b0);
    send_frame(32'd50, 8'd3);
    pulse_cycle_start();
    check("tmo_next_p2width", p2width, 32'd50);
    check("tmo_next_sync_up", sync_up, 32'd2150);

    // Unknown control byte
    e0 = err_cnt;
    send_frame(32'h0403_0201, 8'h09);
    check("bad_err", err_cnt - e0, 1);
    check("bad_ack", u_if.tx_byte, AckEn ? 8'hF5 : 8'h00);
    check("bad_pending", pending, 1'b0);

    // cycle_start during DECODE of a period write commits the old shadow
    send_frame(32'd0, 8'd4);
    send_raw(32'd500000, 8'd1);
    cycle_start = 1'b1;
    tick();
    cycle_start = 1'b0;
    check("dec_cs_pump", pump, 1'b0);
    check("dec_cs_period_old", period, 32'd2000000);
    check("dec_cs_pending", pending, 1'b1);
    tick();
    tick();
    check("dec_cs_ack", u_if.tx_byte, AckEn ? 8'hC8 : 8'h00);
    pulse_cycle_start();
    check("dec_cs_period_new", period, 32'd500000);
    check("dec_cs_pending_clr", pending, 1'b0);

    // recv_error coincident with a byte: abort wins, byte dropped
    e0 = err_cnt;
    send_byte(8'h55);
    send_byte(8'h66);
    u_if.received   = 1'b1;
    u_if.rx_byte    = 8'hAA;
    u_if.recv_error = 1'b1;
    tick();
    u_if.received   = 1'b0;
    u_if.recv_error = 1'b0;
    tick();
    check("rxerr_err", err_cnt - e0, 1);
    check("rxerr_pending", pending, 1'b0);
    send_frame(32'd3000, 8'd0);
    pulse_cycle_start();
    check("rxerr_next_delay", delay, 32'd3000);
    check("rxerr_next_p2start", p2start, 32'd3100);
    check("rxerr_next_sync_up", sync_up, 32'd3150);

    // Transmitter busy holds the acknowledge back
    u_if.is_transmitting = 1'b1;
    t0 = tx_cnt;
    send_raw(32'h0000_0011, 8'd6);
    repeat (4) tick();
    check("busy_no_tx", u_if.transmit, 1'b0);
    check("busy_cnt", tx_cnt - t0, 0);
    check("read_no_pending", pending, 1'b0);
    u_if.is_transmitting = 1'b0;
    #1;
    check("busy_release_tx", u_if.transmit, AckEn);
    check("busy_release_byte", u_if.tx_byte, AckEn ? 8'h11 : 8'h00);
    tick();
    check("busy_release_once", u_if.transmit, 1'b0);
    check("busy_release_cnt", tx_cnt - t0, AckEn ? 1 : 0);

    // Reset mid-frame
    send_byte(8'h01);
    send_byte(8'h02);
    reset = 1'b1;
    #1;
    check("midrst_period", period, 32'd2000000);
    check("midrst_delay", delay, 32'd2000);
    check("midrst_pending", pending, 1'b0);
    check("midrst_tx_byte", u_if.tx_byte, 8'h00);
    tick();
    reset = 1'b0;
    tick();
    send_frame(32'd77, 8'd2);
    pulse_cycle_start();
    check("midrst_p1width", p1width, 32'd77);
    check("midrst_p2start", p2start, 32'd2077);
    check("midrst_sync_up", sync_up, 32'd2107);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
